// File: rtl/execute_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on operand magnitudes, sign fixed at the end.
module execute_muldiv #(
   parameter int XLEN     = 32,
   parameter int BITS_PER = 1,
   parameter bit FAST_DIV = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            busy
);
   localparam int N  = XLEN / BITS_PER;
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic [2:0]      fn;
   logic [XLEN-1:0] hi, lo, opnd, spec_val;
   logic [XLEN-1:0] hi_nxt, lo_nxt, result, dr;
   logic [XLEN-1:0] abs_a, abs_b;
   logic [XLEN:0]   t;
   logic [2*XLEN-1:0] prod;
   logic [CW-1:0]   cnt;
   logic            neg, spec;
   logic            accept, is_div, a_sgn, b_sgn, sa, sb;
   logic            div_zero, ovf;

   assign accept   = in_valid && in_ready && !kill;
   assign is_div   = funct3[2];
   assign a_sgn    = is_div ? ~funct3[0] : ~(funct3[1] & funct3[0]);
   assign b_sgn    = is_div ? ~funct3[0] : ~funct3[1];
   assign sa       = a_sgn & op_a[XLEN-1];
   assign sb       = b_sgn & op_b[XLEN-1];
   assign abs_a    = sa ? -op_a : op_a;
   assign abs_b    = sb ? -op_b : op_b;
   assign div_zero = is_div && (op_b == '0);
   assign ovf      = is_div && !funct3[0]
                     && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (op_b == '1);

   // hi:lo is the product accumulator, or remainder:quotient when dividing
   always_comb begin
      hi_nxt = hi;
      lo_nxt = lo;
      t      = '0;
      for (int i = 0; i < BITS_PER; i++) begin
         if (fn[2]) begin
            t      = {hi_nxt, lo_nxt[XLEN-1]};
            lo_nxt = {lo_nxt[XLEN-2:0], 1'b0};
            if (t >= {1'b0, opnd}) begin
               t         = t - {1'b0, opnd};
               lo_nxt[0] = 1'b1;
            end
            hi_nxt = t[XLEN-1:0];
         end else begin
            t = {1'b0, hi_nxt} + (lo_nxt[0] ? {1'b0, opnd} : '0);
            {hi_nxt, lo_nxt} = {t, lo_nxt[XLEN-1:1]};
         end
      end
   end

   always_comb begin
      prod = neg ? -{hi, lo} : {hi, lo};
      dr   = fn[1] ? hi : lo;
      if (neg) dr = -dr;
      if (spec)                 result = spec_val;
      else if (fn[2])           result = dr;
      else if (fn[1:0] == 2'b00) result = prod[XLEN-1:0];
      else                      result = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fn       <= '0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         neg      <= 1'b0;
         spec     <= 1'b0;
         spec_val <= '0;
         cnt      <= '0;
         out_data <= '0;
      end else if (accept) begin
         fn       <= funct3;
         hi       <= '0;
         lo       <= is_div ? abs_a : abs_b;
         opnd     <= is_div ? abs_b : abs_a;
         neg      <= (is_div && funct3[1]) ? sa : (sa ^ sb);
         spec     <= div_zero || ovf;
         spec_val <= div_zero ? (funct3[1] ? op_a : '1)
                              : (funct3[1] ? '0 : op_a);
         cnt      <= (FAST_DIV && (div_zero || ovf)) ? '0 : CNT_INIT;
      end else if (state == CALC && !kill) begin
         if (cnt != '0) begin
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            cnt <= cnt - CW'(1);
         end else begin
            out_data <= result;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (kill) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state != IDLE);
      out_valid = (state == DONE);
   end
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: 32-bit/1-bit and 64-bit/4-bit instances
// driven from one stimulus stream, checked against a queued scoreboard.
module tb_execute_muldiv;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, kill, out_ready, sel;
   logic [2:0]  funct3;
   logic [63:0] op_a, op_b;
   logic        iv32, iv64, ir32, ir64, ov32, ov64, bz32, bz64;
   logic [31:0] od32;
   logic [63:0] od64;
   logic        ir, ov, bz;
   logic [63:0] od;

   assign iv32 = in_valid & ~sel;
   assign iv64 = in_valid & sel;
   assign ir   = sel ? ir64 : ir32;
   assign ov   = sel ? ov64 : ov32;
   assign bz   = sel ? bz64 : bz32;
   assign od   = sel ? od64 : {32'b0, od32};

   execute_muldiv #(.XLEN(32), .BITS_PER(1), .FAST_DIV(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
      .funct3(funct3), .op_a(op_a[31:0]), .op_b(op_b[31:0]),
      .kill(kill), .out_valid(ov32), .out_ready(out_ready),
      .out_data(od32), .busy(bz32));

   execute_muldiv #(.XLEN(64), .BITS_PER(4), .FAST_DIV(1)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
      .funct3(funct3), .op_a(op_a), .op_b(op_b),
      .kill(kill), .out_valid(ov64), .out_ready(out_ready),
      .out_data(od64), .busy(bz64));

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [2:0] f,
      input logic [63:0] a_in, input logic [63:0] b_in, input bit wide);
      logic [63:0]  mask, mn, a, b, r;
      logic [127:0] sa, sb, ua, ub, p;
      longint       qa, qb;
      bit           ovf;
      mask = wide ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      mn   = wide ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      a    = a_in & mask;
      b    = b_in & mask;
      ua   = {64'b0, a};
      ub   = {64'b0, b};
      sa   = wide ? {{64{a[63]}}, a} : {{96{a[31]}}, a[31:0]};
      sb   = wide ? {{64{b[63]}}, b} : {{96{b[31]}}, b[31:0]};
      qa   = sa[63:0];
      qb   = sb[63:0];
      ovf  = (a == mn) && (b == mask);
      p    = '0;
      r    = '0;
      case (f)
         3'd0, 3'd1: p = sa * sb;
         3'd2:       p = sa * ub;
         3'd3:       p = ua * ub;
         default:    p = '0;
      endcase
      case (f)
         3'd0:    r = p[63:0];
         3'd1, 3'd2, 3'd3: r = wide ? p[127:64] : {32'b0, p[63:32]};
         3'd4:    r = (b == 0) ? mask : ovf ? a : 64'(qa / qb);
         3'd5:    r = (b == 0) ? mask : a / b;
         3'd6:    r = (b == 0) ? a : ovf ? 64'd0 : 64'(qa % qb);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r & mask;
   endfunction

   task automatic wait_valid(output int n);
      n = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk);
         #1;
         if (ov) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic do_op(input bit s, input logic [2:0] f,
      input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] exp, input int hold);
      logic [63:0] mask, mn, d0, e;
      int lat, got;
      bit sp;
      mask = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      mn   = s ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
      sp   = f[2] && (((b & mask) == 0)
             || (!f[0] && (a & mask) == mn && (b & mask) == mask));
      lat  = sp ? 1 : (s ? 17 : 33);
      exp_q.push_back(exp);
      @(negedge clk);
      sel = s;
      funct3 = f;
      op_a = a & mask;
      op_b = b & mask;
      in_valid = 1'b1;
      #1;
      check("in_ready", {63'b0, ir}, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(got);
      check("latency", 64'(got), 64'(lat));
      d0 = od;
      repeat (hold) begin
         @(posedge clk);
         #1;
         check("hold_valid", {63'b0, ov}, 64'd1);
         check("hold_data", od, d0);
         check("hold_ready", {63'b0, ir}, 64'd0);
      end
      e = exp_q.pop_front();
      check("data", od, e);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("release", {62'b0, ov, ir}, 64'd1);
   endtask

   function automatic logic [63:0] rnd(input bit wide);
      logic [63:0] v;
      case ($urandom_range(0, 4))
         0: v = 64'd0;
         1: v = 64'($urandom_range(1, 20));
         2: v = wide ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
         3: v = 64'hFFFF_FFFF_FFFF_FFFF;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   initial begin
      int n;
      logic [63:0] a, b;
      logic [2:0]  f;
      rst_n = 1'b1;
      in_valid = 1'b0;
      kill = 1'b0;
      out_ready = 1'b0;
      sel = 1'b0;
      funct3 = '0;
      op_a = '0;
      op_b = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_ready", {63'b0, ir}, 64'd1);
      check("rst_valid", {63'b0, ov}, 64'd0);
      check("rst_busy", {63'b0, bz}, 64'd0);
      check("rst_data", od, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op(0, 3'd0, 64'd7, 64'hFFFF_FFF9, 64'hFFFF_FFCF, 0);
      do_op(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 0);
      do_op(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 0);
      do_op(0, 3'd2, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF, 0);
      do_op(0, 3'd5, 64'd10, 64'd0, 64'hFFFF_FFFF, 0);
      do_op(0, 3'd7, 64'd10, 64'd0, 64'd10, 0);
      do_op(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0);
      do_op(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 0);
      do_op(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 5);
      do_op(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 5);

      // squash mid-divide, with a competing in_valid on the kill edge
      @(negedge clk);
      sel = 1'b0;
      funct3 = 3'd4;
      op_a = 64'd1000;
      op_b = 64'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      kill = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      in_valid = 1'b0;
      check("kill_busy", {63'b0, bz}, 64'd0);
      check("kill_ready", {63'b0, ir}, 64'd1);
      check("kill_valid", {63'b0, ov}, 64'd0);
      @(posedge clk);
      #1;
      check("kill_idle", {62'b0, bz, ov}, 64'd0);
      do_op(0, 3'd0, 64'd3, 64'd4, 64'd12, 0);

      // kill beats out_ready on a finished result
      @(negedge clk);
      funct3 = 3'd0;
      op_a = 64'd5;
      op_b = 64'd6;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(n);
      check("kdone_lat", 64'(n), 64'd33);
      kill = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      out_ready = 1'b0;
      check("kdone", {62'b0, ov, ir}, 64'd1);

      // asynchronous reset mid-calculation
      @(negedge clk);
      funct3 = 3'd0;
      op_a = 64'd9;
      op_b = 64'd9;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {63'b0, bz}, 64'd0);
      check("arst_ready", {63'b0, ir}, 64'd1);
      check("arst_valid", {63'b0, ov}, 64'd0);
      check("arst_data", od, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(0, 3'd0, 64'd7, 64'hFFFF_FFF9, 64'hFFFF_FFCF, 0);

      // 64-bit, four bits per cycle
      do_op(1, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9,
            64'hFFFF_FFFF_FFFF_FFCF, 0);
      do_op(1, 3'd5, 64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      do_op(1, 3'd7, 64'd10, 64'd0, 64'd10, 0);
      do_op(1, 3'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0000, 0);
      do_op(1, 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
            64'd0, 0);

      for (int i = 0; i < 40; i++) begin
         bit w;
         w = (i >= 24);
         f = 3'($urandom_range(0, 7));
         a = rnd(w);
         b = rnd(w);
         do_op(w, f, a, b, model(f, a, b, w), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
